// File: rtl/gsm_lpc_frame_host.sv
// gsm_lpc_frame_host: loads a sample frame, runs an ap_ctrl_hs LPC kernel once, then streams out its LARc coefficients
// Ports:
//   ap_clk, ap_rst_n             clock (rising edge) and asynchronous active-low reset
//   in_valid/in_ready/in_data    incoming sample stream, accepted only while loading
//   out_valid/out_ready/out_data/out_last  outgoing coefficient stream, last marks coefficient NCOEF-1
//   k_ap_start/done/idle/ready   kernel block-level handshake (idle is status only)
//   so_*                         kernel-side dual-port access to the FRAME_LEN-deep sample buffer
//   LARc_*                       kernel-side dual-port access to the NCOEF-deep coefficient buffer
//   busy, frame_count            kernel in flight; completed frames (wraps)
module gsm_lpc_frame_host #(
  parameter int FRAME_LEN = 160,
  parameter int ADDR_W    = 8,
  parameter int NCOEF     = 8,
  parameter int CADDR_W   = 3,
  parameter int DATA_W    = 16
) (
  input  logic               ap_clk,
  input  logic               ap_rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_last,
  output logic               k_ap_start,
  input  logic               k_ap_done,
  input  logic               k_ap_idle,
  input  logic               k_ap_ready,
  input  logic [ADDR_W-1:0]  so_address0,
  input  logic               so_ce0,
  input  logic               so_we0,
  input  logic [DATA_W-1:0]  so_d0,
  output logic [DATA_W-1:0]  so_q0,
  input  logic [ADDR_W-1:0]  so_address1,
  input  logic               so_ce1,
  input  logic               so_we1,
  input  logic [DATA_W-1:0]  so_d1,
  output logic [DATA_W-1:0]  so_q1,
  input  logic [CADDR_W-1:0] LARc_address0,
  input  logic               LARc_ce0,
  input  logic               LARc_we0,
  input  logic [DATA_W-1:0]  LARc_d0,
  output logic [DATA_W-1:0]  LARc_q0,
  input  logic [CADDR_W-1:0] LARc_address1,
  input  logic               LARc_ce1,
  input  logic               LARc_we1,
  input  logic [DATA_W-1:0]  LARc_d1,
  output logic [DATA_W-1:0]  LARc_q1,
  output logic               busy,
  output logic [15:0]        frame_count
);
  typedef enum logic [1:0] {LOAD, START, RUN, DRAIN} state_t;
  localparam logic [ADDR_W:0]    SO_DEPTH = (ADDR_W+1)'(FRAME_LEN);
  localparam logic [ADDR_W-1:0]  WR_LAST  = ADDR_W'(FRAME_LEN - 1);
  localparam logic [CADDR_W-1:0] RD_LAST  = CADDR_W'(NCOEF - 1);
  state_t state, state_nx;
  logic [ADDR_W-1:0] wr_idx;
  logic [CADDR_W-1:0] rd_idx;
  logic [DATA_W-1:0] so_mem [FRAME_LEN];
  logic [DATA_W-1:0] larc_mem [NCOEF];
  logic in_fire, out_fire, so_ok0, so_ok1, idle_unused;
  assign idle_unused = k_ap_idle;
  assign in_fire = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  // one extra address bit keeps the range check valid even when FRAME_LEN fills the address space
  assign so_ok0 = {1'b0, so_address0} < SO_DEPTH;
  assign so_ok1 = {1'b0, so_address1} < SO_DEPTH;
  always_comb begin
    state_nx = state;
    case (state)
      LOAD:    if (in_fire && wr_idx == WR_LAST) state_nx = START;
      // ap_ready only counts while start is actually presented to the kernel
      START:   if (k_ap_start && k_ap_ready) state_nx = k_ap_done ? DRAIN : RUN;
      RUN:     if (k_ap_done) state_nx = DRAIN;
      DRAIN:   if (out_fire && out_last) state_nx = LOAD;
      default: state_nx = LOAD;
    endcase
  end
  always_comb begin
    in_ready  = state == LOAD;
    busy      = state == START || state == RUN;
    out_valid = state == DRAIN;
    out_last  = out_valid && rd_idx == RD_LAST;
    out_data  = out_valid ? larc_mem[rd_idx] : '0;
  end
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state       <= LOAD;
      wr_idx      <= '0;
      rd_idx      <= '0;
      k_ap_start  <= 1'b0;
      frame_count <= '0;
      so_q0       <= '0;
      so_q1       <= '0;
      LARc_q0     <= '0;
      LARc_q1     <= '0;
    end else begin
      state <= state_nx;
      // rises one cycle into START, falls the cycle after ready is seen
      k_ap_start <= state == START && !(k_ap_start && k_ap_ready);
      if (in_fire) wr_idx <= wr_idx == WR_LAST ? '0 : wr_idx + 1'b1;
      if (out_fire) rd_idx <= out_last ? '0 : rd_idx + 1'b1;
      if (out_fire && out_last) frame_count <= frame_count + 16'd1;
      if (busy && so_ce0 && !so_we0) so_q0 <= so_ok0 ? so_mem[so_address0] : '0;
      if (busy && so_ce1 && !so_we1) so_q1 <= so_ok1 ? so_mem[so_address1] : '0;
      if (busy && LARc_ce0 && !LARc_we0) LARc_q0 <= larc_mem[LARc_address0];
      if (busy && LARc_ce1 && !LARc_we1) LARc_q1 <= larc_mem[LARc_address1];
    end
  end
  // port 1 is written first so a same-address port 0 write overrides it
  always_ff @(posedge ap_clk) begin
    if (in_fire) so_mem[wr_idx] <= in_data;
    if (busy && so_ce1 && so_we1 && so_ok1) so_mem[so_address1] <= so_d1;
    if (busy && so_ce0 && so_we0 && so_ok0) so_mem[so_address0] <= so_d0;
    if (busy && LARc_ce1 && LARc_we1) larc_mem[LARc_address1] <= LARc_d1;
    if (busy && LARc_ce0 && LARc_we0) larc_mem[LARc_address0] <= LARc_d0;
  end
endmodule

// File: tb/tb_gsm_lpc_frame_host.sv
// tb_gsm_lpc_frame_host: table vectors, randomized frames and a behavioural kernel model for gsm_lpc_frame_host
module tb_gsm_lpc_frame_host;
  typedef logic [15:0] frame_t [160];
  typedef logic [15:0] coef_t [8];
  typedef struct {
    logic ce0, we0; logic [7:0] a0; logic [15:0] d0;
    logic ce1, we1; logic [7:0] a1; logic [15:0] d1;
    logic [15:0] q0, q1;
  } vec_t;
  logic ap_clk = 1'b0;
  logic ap_rst_n, in_valid, in_ready, out_valid, out_ready, out_last;
  logic k_ap_start, k_ap_done, k_ap_idle, k_ap_ready, busy;
  logic [15:0] in_data, out_data, frame_count;
  logic [7:0] so_address0, so_address1;
  logic so_ce0, so_we0, so_ce1, so_we1;
  logic [15:0] so_d0, so_d1, so_q0, so_q1;
  logic [2:0] LARc_address0, LARc_address1;
  logic LARc_ce0, LARc_we0, LARc_ce1, LARc_we1;
  logic [15:0] LARc_d0, LARc_d1, LARc_q0, LARc_q1;
  int total = 0, bad = 0, fc = 0, lat;
  frame_t f;
  coef_t kc, e;
  vec_t tbl [9];
  always #5 ap_clk = ~ap_clk;
  gsm_lpc_frame_host dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .k_ap_start(k_ap_start), .k_ap_done(k_ap_done), .k_ap_idle(k_ap_idle), .k_ap_ready(k_ap_ready),
    .so_address0(so_address0), .so_ce0(so_ce0), .so_we0(so_we0), .so_d0(so_d0), .so_q0(so_q0),
    .so_address1(so_address1), .so_ce1(so_ce1), .so_we1(so_we1), .so_d1(so_d1), .so_q1(so_q1),
    .LARc_address0(LARc_address0), .LARc_ce0(LARc_ce0), .LARc_we0(LARc_we0), .LARc_d0(LARc_d0), .LARc_q0(LARc_q0),
    .LARc_address1(LARc_address1), .LARc_ce1(LARc_ce1), .LARc_we1(LARc_we1), .LARc_d1(LARc_d1), .LARc_q1(LARc_q1),
    .busy(busy), .frame_count(frame_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge ap_clk);
    #1;
  endtask
  task automatic mem_idle;
    so_ce0 = 0; so_we0 = 0; so_ce1 = 0; so_we1 = 0;
    LARc_ce0 = 0; LARc_we0 = 0; LARc_ce1 = 0; LARc_we1 = 0;
  endtask
  // reference: each coefficient is the 16-bit wrapped sum of its 20-sample segment
  task automatic model;
    for (int k = 0; k < 8; k++) begin
      e[k] = '0;
      for (int j = 0; j < 20; j++) e[k] += f[20*k+j];
    end
  endtask
  task automatic load(input int n, input bit gaps);
    int idx = 0, cyc = 0;
    logic rdy;
    while (idx < n && cyc < 2000) begin
      in_valid = gaps ? 1'($urandom_range(0, 3) != 0) : 1'b1;
      in_data = f[idx];
      rdy = in_ready;
      tick();
      cyc++;
      if (in_valid && rdy) idx++;
    end
    in_valid = 0;
    chk("load_count", 32'(idx), 32'(n));
  endtask
  task automatic wait_start(output int c);
    c = 0;
    while (!k_ap_start && c < 20) begin
      tick();
      c++;
    end
  endtask
  task automatic ack;
    tick();
    chk("start_hold", 32'(k_ap_start), 1);
    k_ap_ready = 1;
    tick();
    k_ap_ready = 0;
    chk("start_drop", 32'(k_ap_start), 0);
    chk("busy_run", 32'(busy), 1);
  endtask
  // mode 0: fixed 0x0100+i; mode 1: read the whole frame and sum per segment
  task automatic kernel_work(input int mode);
    for (int i = 0; i < 8; i++) kc[i] = mode == 0 ? 16'h0100 + 16'(i) : 16'h0;
    if (mode == 1)
      for (int a = 0; a < 160; a += 2) begin
        so_ce0 = 1; so_address0 = 8'(a); so_ce1 = 1; so_address1 = 8'(a + 1);
        tick();
        kc[a/20] += so_q0 + so_q1;
      end
    mem_idle();
    for (int j = 0; j < 4; j++) begin
      LARc_ce0 = 1; LARc_we0 = 1; LARc_address0 = 3'(2*j); LARc_d0 = kc[2*j];
      LARc_ce1 = 1; LARc_we1 = 1; LARc_address1 = 3'(2*j + 1); LARc_d1 = kc[2*j+1];
      tick();
    end
    LARc_address0 = 3'd3; LARc_d0 = kc[3]; LARc_address1 = 3'd3; LARc_d1 = ~kc[3];
    tick();
    LARc_we0 = 0; LARc_we1 = 0; LARc_address0 = 3'd3; LARc_address1 = 3'd6;
    tick();
    chk("larc_q0", 32'(LARc_q0), 32'(kc[3]));
    chk("larc_q1", 32'(LARc_q1), 32'(kc[6]));
    mem_idle();
  endtask
  task automatic done_pulse;
    k_ap_done = 1;
    tick();
    k_ap_done = 0;
    chk("drain_enter", 32'(out_valid), 1);
  endtask
  task automatic drain(input int mode);
    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    int beat = 0, cyc = 0;
    logic stalled = 1'b0;
    logic [15:0] held = '0;
    while (beat < 8 && cyc < 100) begin
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? pat[cyc % 4] : 1'($urandom_range(0, 1));
      chk("out_valid", 32'(out_valid), 1);
      if (stalled) chk("stall_hold", 32'(out_data), 32'(held));
      if (out_ready) begin
        chk($sformatf("beat%0d_data", beat), 32'(out_data), 32'(e[beat]));
        chk($sformatf("beat%0d_last", beat), 32'(out_last), 32'(beat == 7));
        beat++;
        stalled = 0;
      end else begin
        held = out_data;
        stalled = 1;
      end
      tick();
      cyc++;
    end
    out_ready = 0;
    chk("drain_beats", 32'(beat), 8);
    chk("drain_exit", 32'(out_valid), 0);
    chk("reload_ready", 32'(in_ready), 1);
  endtask
  task automatic do_reset;
    #2 ap_rst_n = 0;
    #1;
    chk("rst_start", 32'(k_ap_start), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(frame_count), 0);
    k_ap_ready = 0; k_ap_done = 0; in_valid = 0; mem_idle();
    tick();
    ap_rst_n = 1;
    fc = 0;
  endtask
  task automatic rand_frame;
    for (int i = 0; i < 160; i++) f[i] = 16'($urandom);
  endtask
  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'd37,  16'h0,    1'b1, 1'b0, 8'd159, 16'h0,    16'd37,   16'd159};
    tbl[1] = '{1'b1, 1'b1, 8'd5,   16'hAAAA, 1'b1, 1'b1, 8'd5,   16'h5555, 16'd37,   16'd159};
    tbl[2] = '{1'b1, 1'b0, 8'd5,   16'h0,    1'b1, 1'b1, 8'd6,   16'h1234, 16'hAAAA, 16'd159};
    tbl[3] = '{1'b1, 1'b1, 8'd6,   16'hBEEF, 1'b1, 1'b0, 8'd6,   16'h0,    16'hAAAA, 16'h1234};
    tbl[4] = '{1'b1, 1'b0, 8'd6,   16'h0,    1'b1, 1'b0, 8'd200, 16'h0,    16'hBEEF, 16'h0};
    tbl[5] = '{1'b1, 1'b1, 8'd200, 16'hDEAD, 1'b1, 1'b0, 8'd159, 16'h0,    16'hBEEF, 16'd159};
    tbl[6] = '{1'b1, 1'b0, 8'd200, 16'h0,    1'b1, 1'b0, 8'd5,   16'h0,    16'h0,    16'hAAAA};
    tbl[7] = '{1'b0, 1'b0, 8'd0,   16'h0,    1'b0, 1'b0, 8'd0,   16'h0,    16'h0,    16'hAAAA};
    tbl[8] = '{1'b1, 1'b0, 8'd1,   16'h0,    1'b1, 1'b0, 8'd0,   16'h0,    16'd1,    16'd0};
    ap_rst_n = 0; in_valid = 0; in_data = 0; out_ready = 0;
    k_ap_done = 0; k_ap_idle = 1; k_ap_ready = 0;
    so_address0 = 0; so_address1 = 0; so_d0 = 0; so_d1 = 0;
    LARc_address0 = 0; LARc_address1 = 0; LARc_d0 = 0; LARc_d1 = 0;
    mem_idle();
    tick(); tick();
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_start", 32'(k_ap_start), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_count", 32'(frame_count), 0);
    chk("rst_q", 32'({so_q0, so_q1}), 0);
    chk("rst_larc_q", 32'({LARc_q0, LARc_q1}), 0);
    ap_rst_n = 1;
    tick();
    for (int i = 0; i < 160; i++) f[i] = 16'(i);
    load(160, 0);
    chk("ready_fall", 32'(in_ready), 0);
    chk("busy_start", 32'(busy), 1);
    chk("start_first", 32'(k_ap_start), 0);
    wait_start(lat);
    chk("start_latency", 32'(lat), 1);
    ack();
    for (int i = 0; i < 9; i++) begin
      so_ce0 = tbl[i].ce0; so_we0 = tbl[i].we0; so_address0 = tbl[i].a0; so_d0 = tbl[i].d0;
      so_ce1 = tbl[i].ce1; so_we1 = tbl[i].we1; so_address1 = tbl[i].a1; so_d1 = tbl[i].d1;
      tick();
      chk($sformatf("tbl%0d_q0", i), 32'(so_q0), 32'(tbl[i].q0));
      chk($sformatf("tbl%0d_q1", i), 32'(so_q1), 32'(tbl[i].q1));
    end
    mem_idle();
    kernel_work(0);
    done_pulse();
    for (int i = 0; i < 8; i++) e[i] = 16'h0100 + 16'(i);
    drain(1);
    fc++;
    chk("frame_count", 32'(frame_count), 32'(fc));
    so_ce0 = 1; so_address0 = 8'd37;
    tick();
    chk("q_hold_idle", 32'(so_q0), 1);
    mem_idle();
    for (int r = 0; r < 3; r++) begin
      rand_frame();
      model();
      load(160, 1);
      wait_start(lat);
      chk("start_latency", 32'(lat), 1);
      if (r == 1) begin
        kernel_work(1);
        chk("start_held", 32'(k_ap_start), 1);
        k_ap_ready = 1; k_ap_done = 1;
        tick();
        k_ap_ready = 0; k_ap_done = 0;
        chk("direct_drain", 32'(out_valid), 1);
        chk("direct_start", 32'(k_ap_start), 0);
      end else begin
        ack();
        kernel_work(1);
        done_pulse();
      end
      drain(2);
      fc++;
      chk("frame_count", 32'(frame_count), 32'(fc));
    end
    rand_frame();
    load(160, 1);
    wait_start(lat);
    do_reset();
    rand_frame();
    load(160, 0);
    wait_start(lat);
    ack();
    do_reset();
    rand_frame();
    load(50, 1);
    do_reset();
    rand_frame();
    model();
    load(160, 1);
    wait_start(lat);
    chk("start_latency", 32'(lat), 1);
    ack();
    kernel_work(1);
    done_pulse();
    drain(0);
    fc++;
    chk("frame_count", 32'(frame_count), 32'(fc));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/gsm_lpc_frame_host.md
Name: gsm_lpc_frame_host

Overview:
- Host-side counterpart to the generated GSM LPC analysis top. It initiates the ap_ctrl_hs handshake: drives ap_start and consumes ap_done, ap_idle and ap_ready.
- It serves both dual-port memory interfaces as the responder: the 160-sample so buffer and the 8-entry LARc buffer.
- It collects a frame of samples from a valid/ready stream, runs the kernel once, then streams the 8 LARc coefficients out.

Parameters:
- FRAME_LEN, 160, samples per frame; so buffer depth.
- ADDR_W, 8, so address width.
- NCOEF, 8, LARc buffer depth.
- CADDR_W, 3, LARc address width.
- DATA_W, 16, sample and coefficient width.

Ports:
- ap_clk  in  1  clock; all logic on rising edge.
- ap_rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input sample valid.
- in_ready  out  1  host accepts a sample.
- in_data  in  DATA_W  input sample.
- out_valid  out  1  coefficient valid.
- out_ready  in  1  downstream accepts a coefficient.
- out_data  out  DATA_W  LARc coefficient.
- out_last  out  1  marks coefficient NCOEF-1.
- k_ap_start  out  1  kernel start.
- k_ap_done  in  1  kernel done.
- k_ap_idle  in  1  kernel idle (status only).
- k_ap_ready  in  1  kernel ready.
- so_address0/so_address1  in  ADDR_W  kernel so port addresses.
- so_ce0/so_ce1, so_we0/so_we1  in  1  enables.
- so_d0/so_d1  in  DATA_W  write data.
- so_q0/so_q1  out  DATA_W  read data.
- LARc_address0/LARc_address1  in  CADDR_W  addresses.
- LARc_ce0/LARc_ce1, LARc_we0/LARc_we1  in  1  enables.
- LARc_d0/LARc_d1  in  DATA_W  write data.
- LARc_q0/LARc_q1  out  DATA_W  read data.
- busy  out  1  high in START or RUN.
- frame_count  out  16  completed frames; wraps at 65535 to 0.

Behaviour:
- The reset is asynchronous active-low and one clock (ap_clk) drives all logic.
- Reset values:
  - state LOAD, so in_ready=1.
  - k_ap_start=0, out_valid=0, out_last=0, out_data=0, busy=0, frame_count=0.
  - all q outputs 0; load and drain counters 0.
  - Memory contents are not cleared.
- LOAD state:
  - in_ready=1.
  - Each in_valid&in_ready writes in_data to so[wr_idx], then wr_idx increments.
  - The handshake at wr_idx=FRAME_LEN-1 moves the FSM to START next cycle; wr_idx returns to 0.
- START state:
  - k_ap_start is registered. It rises the cycle after entering START and holds until a cycle with k_ap_ready=1, then drops the following cycle.
  - The FSM moves to RUN in the same cycle k_ap_ready is sampled high.
  - If k_ap_done=1 is sampled together with k_ap_ready, go straight to DRAIN.
- RUN state:
  - k_ap_start=0.
  - k_ap_done=1 sampled -> DRAIN next cycle.
- Memory responder:
  - Active in START and RUN only; outside these states, ce/we inputs are ignored and q holds.
  - Each port with ce=1 and we=0 registers mem[addr] to q at the next edge: read latency 1, read-first.
  - Each port with ce=1 and we=1 writes d at the edge; q holds.
  - Both ports writing the same address in one cycle: port 0 wins.
  - Read on one port and write on the other to the same address: the read returns the old data.
  - so addresses >= FRAME_LEN: writes are dropped, reads return 0.
- DRAIN state:
  - out_valid=1 and out_data=LARc[rd_idx], driven combinationally from state and rd_idx.
  - out_last = (rd_idx==NCOEF-1).
  - Each out_valid&out_ready increments rd_idx.
  - The handshake with out_last -> LOAD next cycle; rd_idx=0; frame_count+1.
  - out_data is stable while out_valid=1 and out_ready=0.
- Input back-pressure: in_ready=0 in START, RUN and DRAIN; in_valid is ignored there.
- Reset mid-operation: every state returns to LOAD immediately and k_ap_start drops asynchronously. A partially loaded frame is discarded.
- k_ap_idle has no effect on the FSM.

Test Plan:
- Reset, then 160 samples 0..159 with in_valid held -> in_ready falls the cycle after sample 159. k_ap_start rises next cycle; busy=1.
- Kernel model reads so[37] via port0 and so[159] via port1 in the same cycle -> so_q0=37 and so_q1=159 the next cycle.
- Kernel writes LARc[0..7]=0x0100+i, asserts ready (1 cycle after start), then done. With out_ready=1: 8 beats 0x0100..0x0107, out_last on beat 7, frame_count=1.
- out_ready toggled 1,0,0,1 during DRAIN -> out_data held while stalled, no beat lost or duplicated.
- Both so ports write address 5 in the same cycle (port0=0xAAAA, port1=0x5555) -> a later read returns 0xAAAA.
- ap_rst_n asserted in RUN mid-frame -> k_ap_start=0 and in_ready=1 immediately. A new 160-sample frame processes correctly and frame_count is unchanged by the aborted frame.
